// File: rtl/ctrl_pipe_unit.sv
// Registered control decoder: decodes the ID opcode into a control bundle and
// carries it through EX/MEM/WB, with stall/flush, illegal detection and EBREAK drain-and-halt.
module ctrl_pipe_unit #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter bit          TRAP_ILLEGAL = 1'b1,
  parameter int unsigned OPCODE_W     = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [OPCODE_W-1:0] id_opcode,
  input  logic                id_bit20,
  input  logic                stall,
  input  logic                flush,
  input  logic                resume,
  output logic                ex_valid,
  output logic                ex_alusrc,
  output logic                ex_branch,
  output logic                ex_jump,
  output logic [1:0]          ex_aluop,
  output logic                mem_valid,
  output logic                mem_memread,
  output logic                mem_memwrite,
  output logic                wb_valid,
  output logic                wb_regwrite,
  output logic [1:0]          wb_sel,
  output logic                pc_hold,
  output logic                halted,
  output logic                illegal
);

  localparam logic [OPCODE_W-1:0] OP_R      = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_LOAD   = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_STORE  = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_BRANCH = OPCODE_W'(7'b1100011);
  localparam logic [OPCODE_W-1:0] OP_LUI    = OPCODE_W'(7'b0110111);
  localparam logic [OPCODE_W-1:0] OP_JAL    = OPCODE_W'(7'b1101111);
  localparam logic [OPCODE_W-1:0] OP_JALR   = OPCODE_W'(7'b1100111);
  localparam logic [OPCODE_W-1:0] OP_IMM    = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] OP_AUIPC  = OPCODE_W'(7'b0010111);
  localparam logic [OPCODE_W-1:0] OP_FENCE  = OPCODE_W'(7'b0001111);
  localparam logic [OPCODE_W-1:0] OP_SYSTEM = OPCODE_W'(7'b1110011);

  localparam int unsigned CNT_W      = 4;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  typedef struct packed {
    logic       valid;
    logic       alusrc;
    logic [1:0] aluop;
    logic       branch;
    logic       jump;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic [1:0] sel;
  } ex_ctrl_t;

  typedef struct packed {
    logic       valid;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic [1:0] sel;
  } mem_ctrl_t;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic [1:0] sel;
  } wb_ctrl_t;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALTED
  } state_t;

  function automatic ex_ctrl_t mk_ctrl(logic alusrc, logic [1:0] aluop, logic branch,
                                       logic jump, logic memread, logic memwrite,
                                       logic regwrite, logic [1:0] sel);
    ex_ctrl_t c;
    c.valid    = 1'b1;
    c.alusrc   = alusrc;
    c.aluop    = aluop;
    c.branch   = branch;
    c.jump     = jump;
    c.memread  = memread;
    c.memwrite = memwrite;
    c.regwrite = regwrite;
    c.sel      = sel;
    return c;
  endfunction

  ex_ctrl_t   dec;
  logic       dec_known;
  logic       dec_ebreak;
  logic       accept;

  ex_ctrl_t   ex_q;
  mem_ctrl_t  mem_q;
  wb_ctrl_t   wb_q;
  logic       illegal_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every combinational output gets a default before the case, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    dec        = '0;
    dec_known  = 1'b1;
    dec_ebreak = 1'b0;
    unique case (id_opcode)
      OP_R:             dec = mk_ctrl(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
      OP_LOAD:          dec = mk_ctrl(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01);
      OP_STORE:         dec = mk_ctrl(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
      OP_BRANCH:        dec = mk_ctrl(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      OP_LUI:           dec = mk_ctrl(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
      OP_JAL, OP_JALR:  dec = mk_ctrl(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10);
      OP_IMM:           dec = mk_ctrl(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
      OP_AUIPC:         dec = mk_ctrl(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
      OP_FENCE:         dec.valid = 1'b1;
      OP_SYSTEM: begin
        // ECALL and EBREAK are both architectural NOPs; only EBREAK halts.
        dec.valid  = 1'b1;
        dec_ebreak = id_bit20;
      end
      default:          dec_known = 1'b0;
    endcase
  end

  assign accept = id_valid & ~stall & ~flush & (state_q == S_RUN);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, which is what lets MEM <= EX and WB <= MEM chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      // Stall, flush, drain/halt and undefined opcodes all load a bubble.
      ex_q           <= accept ? dec : '0;
      mem_q.valid    <= ex_q.valid;
      mem_q.memread  <= ex_q.memread;
      mem_q.memwrite <= ex_q.memwrite;
      mem_q.regwrite <= ex_q.regwrite;
      mem_q.sel      <= ex_q.sel;
      wb_q.valid     <= mem_q.valid;
      wb_q.regwrite  <= mem_q.regwrite;
      wb_q.sel       <= mem_q.sel;
      illegal_q      <= TRAP_ILLEGAL & accept & ~dec_known;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_RUN: begin
        if (accept && dec_ebreak) begin
          state_d = S_DRAIN;
          cnt_d   = DRAIN_LOAD;
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) state_d = S_HALTED;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_HALTED: begin
        if (resume) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  assign ex_valid     = ex_q.valid;
  assign ex_alusrc    = ex_q.alusrc;
  assign ex_aluop     = ex_q.aluop;
  assign ex_branch    = ex_q.branch;
  assign ex_jump      = ex_q.jump;
  assign mem_valid    = mem_q.valid;
  assign mem_memread  = mem_q.memread;
  assign mem_memwrite = mem_q.memwrite;
  assign wb_valid     = wb_q.valid;
  assign wb_regwrite  = wb_q.regwrite;
  assign wb_sel       = wb_q.sel;
  assign illegal      = illegal_q;
  assign halted       = (state_q == S_HALTED);
  assign pc_hold      = stall | (state_q != S_RUN);

endmodule
